// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
// Control/status bundle between a controller (master) and countdown_timer
// (slave).
//   i_start      : load i_load_value and start/restart the countdown
//   i_pause      : level-sensitive freeze while running
//   i_load_value : duration in units, sampled with i_start
//   o_busy       : high while running (including paused)
//   o_done       : one-cycle pulse when the count reaches zero
//   o_tick       : one-cycle pulse on every decrement
//   o_remaining  : current remaining units
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface countdown_timer_if #(
  parameter int WIDTH = 16
) ();
  logic             i_start;
  logic             i_pause;
  logic [WIDTH-1:0] i_load_value;
  logic             o_busy;
  logic             o_done;
  logic             o_tick;
  logic [WIDTH-1:0] o_remaining;

  modport master (
    output i_start, i_pause, i_load_value,
    input  o_busy, o_done, o_tick, o_remaining
  );

  modport slave (
    input  i_start, i_pause, i_load_value,
    output o_busy, o_done, o_tick, o_remaining
  );
endinterface

`default_nettype wire

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// Loadable down-counting timer with prescaler, pause and a done pulse.
// A start loads the duration (in units of PRESCALE clocks) and runs until
// o_remaining reaches zero, emitting o_tick per decrement and o_done at the
// end. All outputs are registered.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : countdown_timer_if.slave (start/pause/load in, status out)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module countdown_timer #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE       = 4,
  parameter int PRESCALE_WIDTH = 16
) (
  input  wire logic        i_clk,
  input  wire logic        i_reset,
  countdown_timer_if.slave bus
);

  localparam logic [PRESCALE_WIDTH-1:0] c_PRE_MAX = PRESCALE_WIDTH'(PRESCALE - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [WIDTH-1:0]          r_remaining;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_tick;

  state_t                    w_state_nxt;
  logic [PRESCALE_WIDTH-1:0] w_prescale_nxt;
  logic [WIDTH-1:0]          w_remaining_nxt;
  logic                      w_done_nxt;
  logic                      w_tick_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_prescale  <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prescale  <= w_prescale_nxt;
      r_remaining <= w_remaining_nxt;
      // Registered busy mirrors the next state so it lines up with o_remaining.
      r_busy      <= (w_state_nxt == S_RUN);
      r_done      <= w_done_nxt;
      r_tick      <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_prescale_nxt  = r_prescale;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    w_tick_nxt      = 1'b0;

    if (bus.i_start) begin
      // Start/restart wins over pause and over a decrement due this cycle.
      w_prescale_nxt = '0;
      if (bus.i_load_value == '0) begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = '0;
        w_done_nxt      = 1'b1;
      end else begin
        w_state_nxt     = S_RUN;
        w_remaining_nxt = bus.i_load_value;
      end
    end else if (r_state == S_RUN && !bus.i_pause) begin
      if (r_prescale != c_PRE_MAX) begin
        w_prescale_nxt = r_prescale + PRESCALE_WIDTH'(1);
      end else begin
        w_prescale_nxt = '0;
        // Guard keeps the count from wrapping below zero.
        if (r_remaining != '0) begin
          w_remaining_nxt = r_remaining - WIDTH'(1);
          w_tick_nxt      = 1'b1;
          if (r_remaining == WIDTH'(1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_tick      = r_tick;
  assign bus.o_remaining = r_remaining;

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer with a prescaler, start/pause control, and a one-cycle done pulse. It sits in the game-control path alongside the free-running up counter. The game FSM uses it for timed waits such as dealer draw delays, display hold times, and bet timeouts: it loads a duration, then waits for `o_done` instead of comparing a counter value against a top.

## Interface
Parameters:
- `WIDTH`, 16, width of the loaded duration and of `o_remaining`.
- `PRESCALE`, 4, clock cycles per unit of duration; must be ≥ 1.
- `PRESCALE_WIDTH`, 16, width of the internal prescaler; must hold `PRESCALE-1`.

Ports:
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  load `i_load_value` and start/restart the countdown; sampled every cycle.
- `i_pause`  in  1  high freezes the prescaler and `o_remaining`; level-sensitive.
- `i_load_value`  in  `WIDTH`  duration in units, sampled only when `i_start` is high.
- `o_busy`  out  1  high while in RUN, including while paused.
- `o_done`  out  1  one-cycle pulse when the countdown reaches 0.
- `o_tick`  out  1  one-cycle pulse on every decrement of `o_remaining`.
- `o_remaining`  out  `WIDTH`  current remaining units.

## Operation
- States: IDLE, RUN. All outputs are registered.
- Reset, which has priority over everything:
  - state goes to IDLE;
  - prescaler and `o_remaining` go to 0;
  - `o_busy`, `o_done` and `o_tick` go to 0.
- IDLE:
  - `o_remaining` holds its last value.
  - `i_pause` is ignored.
  - `i_start` with `i_load_value` = 0: stay in IDLE, set `o_remaining` = 0, pulse `o_done` in the next cycle, no `o_tick`.
  - `i_start` with `i_load_value` = N > 0: load `o_remaining` = N, clear the prescaler, go to RUN.
- RUN, with `i_start` low:
  - If `i_pause` is high, hold everything.
  - Otherwise, if prescaler ≠ `PRESCALE-1`, increment the prescaler.
  - Otherwise, clear the prescaler, decrement `o_remaining`, and pulse `o_tick`.
  - If that decrement takes `o_remaining` from 1 to 0, also pulse `o_done` and go to IDLE.
- RUN, with `i_start` high: restart.
  - Reload from `i_load_value` and clear the prescaler.
  - This applies even on the cycle that would have finished the count; the restart wins, so no `o_done` and no `o_tick`.
  - A reload value of 0 behaves as in IDLE: go to IDLE and pulse `o_done`.
- `i_start` and `i_pause` high together: the load happens. The pause then applies from the next cycle if it is still asserted.
- `o_remaining` never wraps below 0. The decrement only happens from values ≥ 1.

## Timing
- Define edge 0 as the edge where `i_start` is sampled high with N > 0.
- After edge 0:
  - `o_busy` = 1;
  - `o_remaining` = N;
  - prescaler = 0.
- With no pause, `o_remaining` decrements at edges k·`PRESCALE`, for k = 1..N.
- `o_tick` is high for the cycle after each of those edges.
- At edge N·`PRESCALE`:
  - `o_remaining` = 0;
  - `o_done` = 1 and `o_tick` = 1 for that single cycle;
  - `o_busy` = 0.
- Total `o_busy` high time is N·`PRESCALE` cycles, plus one cycle for every cycle that `i_pause` was sampled high in RUN.
- `PRESCALE` = 1: decrement on every unpaused RUN cycle.
- Zero-length start: `o_done` is high for the cycle after the start edge, and `o_busy` stays 0.
- Back-to-back operation: an `i_start` in the same cycle that `o_done` is high is accepted normally. That start is sampled at the next edge.

## Test plan
Unless stated otherwise, tests use `WIDTH`=8, `PRESCALE`=4.
1. Basic count:
   - Stimulus: reset, then start with value 3.
   - Required: `o_busy` high for 12 cycles; `o_remaining` steps 3→2→1→0 at edges 4, 8, 12.
   - Required: `o_tick` pulses ×3; `o_done` is a single pulse coincident with the last tick.
2. Zero load:
   - Stimulus: start with value 0 from IDLE.
   - Required: `o_done` high for exactly one cycle; `o_busy` and `o_tick` never high; `o_remaining` = 0.
3. Pause:
   - Stimulus: start with 2, hold `i_pause` high for 5 cycles starting at cycle 2.
   - Required: `o_remaining` and the prescaler are frozen during the pause; `o_done` comes at edge 13 instead of 8; `o_busy` stays high throughout.
4. Restart:
   - Stimulus: start with 5; at edge 6 assert start with 2.
   - Required: `o_remaining` = 2 after edge 6; decrements at edges 10 and 14; only one `o_done`, at edge 14.
5. Reset mid-run:
   - Stimulus: start with 200; assert `i_reset` at edge 50.
   - Required: after that edge, all outputs are 0 and the state is IDLE.
   - Required: `i_pause` and `i_load_value` are ignored until the next start.
6. `PRESCALE`=1 build:
   - Stimulus: start with 255 (max value).
   - Required: 255 consecutive `o_tick` pulses; `o_done` 255 cycles after the start edge; no wrap below 0.
